// File: rtl/blastn_hit_collector_if.sv
// blastn_hit_collector_if: per-channel hit inputs and FIFO read-out port of the hit collector
interface blastn_hit_collector_if #(
    parameter int NUM_CH = 4,
    parameter int ADDR_W = 8,
    parameter int LEN_W  = 8,
    parameter int DEPTH  = 16
);
    localparam int CH_W  = $clog2(NUM_CH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [NUM_CH-1:0]        ch_valid;
    logic [NUM_CH-1:0]        ch_ready;
    logic [NUM_CH*ADDR_W-1:0] ch_q_addr;
    logic [NUM_CH*ADDR_W-1:0] ch_s_addr;
    logic [NUM_CH*LEN_W-1:0]  ch_len;
    logic [LEN_W-1:0]         min_len;
    logic                     rd_en;
    logic [ADDR_W-1:0]        rd_q_addr;
    logic [ADDR_W-1:0]        rd_s_addr;
    logic [LEN_W-1:0]         rd_len;
    logic [CH_W-1:0]          rd_ch;
    logic                     rd_valid;
    logic                     empty;
    logic                     full;
    logic [CNT_W-1:0]         count;
    logic [15:0]              filt_cnt;

    modport master (
        output ch_valid, ch_q_addr, ch_s_addr, ch_len, min_len, rd_en,
        input  ch_ready, rd_q_addr, rd_s_addr, rd_len, rd_ch, rd_valid, empty, full, count, filt_cnt
    );

    modport slave (
        input  ch_valid, ch_q_addr, ch_s_addr, ch_len, min_len, rd_en,
        output ch_ready, rd_q_addr, rd_s_addr, rd_len, rd_ch, rd_valid, empty, full, count, filt_cnt
    );
endinterface

// File: rtl/blastn_hit_collector.sv
// blastn_hit_collector: merges NUM_CH hit channels through one-entry holds and a round-robin
// arbiter into a summary FIFO, translating channel-local query addresses to global ones.
// Optional length filter enabled by defining BLASTN_HIT_FILTER_EN.
module blastn_hit_collector #(
    parameter int NUM_CH  = 4,
    parameter int SEG_LEN = 32,
    parameter int ADDR_W  = 8,
    parameter int LEN_W   = 8,
    parameter int DEPTH   = 16
) (
    input logic                   array_clk,
    input logic                   reset,
    blastn_hit_collector_if.slave bus
);
    localparam int CH_W  = $clog2(NUM_CH);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int REC_W = 2 * ADDR_W + LEN_W + CH_W;

    logic [ADDR_W-1:0] r_hold_q   [NUM_CH];
    logic [ADDR_W-1:0] r_hold_s   [NUM_CH];
    logic [LEN_W-1:0]  r_hold_len [NUM_CH];
    logic [NUM_CH-1:0] r_hold_v;
    logic [CH_W-1:0]   r_ptr;
    logic [REC_W-1:0]  r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [15:0]       r_filt_cnt;
    logic [ADDR_W-1:0] r_rd_q;
    logic [ADDR_W-1:0] r_rd_s;
    logic [LEN_W-1:0]  r_rd_len;
    logic [CH_W-1:0]   r_rd_ch;
    logic              r_rd_valid;

    logic [NUM_CH-1:0] w_grant;
    logic [NUM_CH-1:0] w_hs;
    logic [NUM_CH-1:0] w_drop;
    logic [NUM_CH-1:0] w_load;
    logic              w_gnt_any;
    logic [CH_W-1:0]   w_gnt_idx;
    logic [ADDR_W-1:0] w_q_global;
    logic [REC_W-1:0]  w_wr_rec;
    logic [16:0]       w_filt_sum;
    logic              w_full;
    logic              w_empty;
    logic              w_pop;

    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_pop   = bus.rd_en & ~w_empty;
    assign w_hs    = bus.ch_valid & bus.ch_ready;
    assign w_load  = w_hs & ~w_drop;

    // round-robin search starting just after the last granted channel; nothing granted while full
    always_comb begin
        logic [CH_W-1:0] cidx;
        w_grant   = '0;
        w_gnt_any = 1'b0;
        w_gnt_idx = '0;
        cidx      = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            cidx = CH_W'((int'(r_ptr) + k) % NUM_CH);
            if (!w_gnt_any && !w_full && r_hold_v[cidx]) begin
                w_gnt_any     = 1'b1;
                w_gnt_idx     = cidx;
                w_grant[cidx] = 1'b1;
            end
        end
    end

    // global query address: channel i covers query offset (NUM_CH-1-i)*SEG_LEN
    always_comb begin
        w_q_global = r_hold_q[w_gnt_idx] + ADDR_W'((NUM_CH - 1 - int'(w_gnt_idx)) * SEG_LEN);
        w_wr_rec   = {w_q_global, r_hold_s[w_gnt_idx], r_hold_len[w_gnt_idx], w_gnt_idx};
    end

`ifdef BLASTN_HIT_FILTER_EN
    // short hits complete their handshake but are not held
    always_comb begin
        w_drop = '0;
        for (int i = 0; i < NUM_CH; i++)
            w_drop[i] = w_hs[i] & (bus.ch_len[i*LEN_W +: LEN_W] < bus.min_len);
    end
`else
    assign w_drop = '0;
`endif

    // number of hits discarded this edge added to the running total
    always_comb begin
        w_filt_sum = {1'b0, r_filt_cnt};
        for (int i = 0; i < NUM_CH; i++)
            w_filt_sum = w_filt_sum + 17'(w_drop[i]);
    end

    // holding registers: a fresh capture wins over the clear caused by a grant
    always_ff @(posedge array_clk or negedge reset) begin
        if (!reset) begin
            r_hold_v <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                r_hold_q[i]   <= '0;
                r_hold_s[i]   <= '0;
                r_hold_len[i] <= '0;
            end
        end else begin
            r_hold_v <= w_load | (r_hold_v & ~w_grant);
            for (int i = 0; i < NUM_CH; i++) begin
                if (w_load[i]) begin
                    r_hold_q[i]   <= bus.ch_q_addr[i*ADDR_W +: ADDR_W];
                    r_hold_s[i]   <= bus.ch_s_addr[i*ADDR_W +: ADDR_W];
                    r_hold_len[i] <= bus.ch_len[i*LEN_W +: LEN_W];
                end
            end
        end
    end

    // arbiter pointer, FIFO pointers/occupancy and filter counter
    always_ff @(posedge array_clk or negedge reset) begin
        if (!reset) begin
            r_ptr      <= CH_W'(NUM_CH - 1);
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_filt_cnt <= '0;
        end else begin
            if (w_gnt_any)
                r_ptr <= w_gnt_idx;
            r_wr_ptr   <= r_wr_ptr + PTR_W'(w_gnt_any);
            r_rd_ptr   <= r_rd_ptr + PTR_W'(w_pop);
            r_count    <= r_count + CNT_W'(w_gnt_any) - CNT_W'(w_pop);
            r_filt_cnt <= w_filt_sum[16] ? 16'hFFFF : w_filt_sum[15:0];
        end
    end

    // FIFO storage; stale contents are harmless because occupancy is reset
    always_ff @(posedge array_clk) begin
        if (w_gnt_any)
            r_mem[r_wr_ptr] <= w_wr_rec;
    end

    // registered read-out of the FIFO head
    always_ff @(posedge array_clk or negedge reset) begin
        if (!reset) begin
            r_rd_q     <= '0;
            r_rd_s     <= '0;
            r_rd_len   <= '0;
            r_rd_ch    <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= w_pop;
            if (w_pop)
                {r_rd_q, r_rd_s, r_rd_len, r_rd_ch} <= r_mem[r_rd_ptr];
        end
    end

    assign bus.ch_ready  = ~r_hold_v | w_grant;
    assign bus.rd_q_addr = r_rd_q;
    assign bus.rd_s_addr = r_rd_s;
    assign bus.rd_len    = r_rd_len;
    assign bus.rd_ch     = r_rd_ch;
    assign bus.rd_valid  = r_rd_valid;
    assign bus.empty     = w_empty;
    assign bus.full      = w_full;
    assign bus.count     = r_count;
    assign bus.filt_cnt  = r_filt_cnt;
endmodule

// File: tb/tb_blastn_hit_collector.sv
// tb_blastn_hit_collector: randomized and directed scoreboard bench for blastn_hit_collector
module tb_blastn_hit_collector;
    localparam int NUM_CH  = 4;
    localparam int SEG_LEN = 32;
    localparam int ADDR_W  = 8;
    localparam int LEN_W   = 8;
    localparam int DEPTH   = 16;
`ifdef BLASTN_HIT_FILTER_EN
    localparam int FILT_ON = 1;
`else
    localparam int FILT_ON = 0;
`endif

    typedef struct {
        int ch;
        int q;
        int s;
        int len;
    } rec_t;

    logic array_clk;
    logic reset;
    int   total = 0;
    int   bad = 0;
    int   n_pop = 0;
    int   exp_filt = 0;
    rec_t exp_q[$];
    int   ch_log[$];

    blastn_hit_collector_if #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .DEPTH(DEPTH)) bus ();

    blastn_hit_collector #(
        .NUM_CH(NUM_CH), .SEG_LEN(SEG_LEN), .ADDR_W(ADDR_W), .LEN_W(LEN_W), .DEPTH(DEPTH)
    ) dut (
        .array_clk(array_clk),
        .reset(reset),
        .bus(bus)
    );

    initial array_clk = 1'b0;
    always #5 array_clk = ~array_clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic set_ch(input int i, input logic v, input int q, input int s, input int len);
        bus.ch_valid[i] = v;
        bus.ch_q_addr[i*ADDR_W +: ADDR_W] = ADDR_W'(q);
        bus.ch_s_addr[i*ADDR_W +: ADDR_W] = ADDR_W'(s);
        bus.ch_len[i*LEN_W +: LEN_W] = LEN_W'(len);
    endtask

    task automatic rand_ch(input int i, input logic v);
        set_ch(i, v, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 15));
    endtask

    // reference: an accepted hit either is filtered or is expected later, globally addressed
    task automatic accept(input int i);
        rec_t r;
        r.ch  = i;
        r.q   = (int'(bus.ch_q_addr[i*ADDR_W +: ADDR_W]) + (NUM_CH - 1 - i) * SEG_LEN) % (1 << ADDR_W);
        r.s   = int'(bus.ch_s_addr[i*ADDR_W +: ADDR_W]);
        r.len = int'(bus.ch_len[i*LEN_W +: LEN_W]);
        if (FILT_ON != 0 && r.len < int'(bus.min_len)) begin
            if (exp_filt < 65535)
                exp_filt++;
        end else begin
            exp_q.push_back(r);
        end
    endtask

    // inputs change at negedge; handshakes are observed just before the rising edge
    task automatic step();
        #4;
        for (int i = 0; i < NUM_CH; i++)
            if (bus.ch_valid[i] && bus.ch_ready[i])
                accept(i);
        @(negedge array_clk);
    endtask

    task automatic reset_pulse();
        bus.ch_valid = '0;
        bus.rd_en = 1'b0;
        reset = 1'b0;
        exp_q.delete();
        exp_filt = 0;
        @(negedge array_clk);
        reset = 1'b1;
        @(negedge array_clk);
    endtask

    task automatic drain();
        int n;
        n = 0;
        bus.ch_valid = '0;
        bus.rd_en = 1'b1;
        while ((exp_q.size() != 0 || !bus.empty || bus.rd_valid) && n < 200) begin
            step();
            n++;
        end
        check("drain within budget", n < 200, 1);
        check("scoreboard left over", exp_q.size(), 0);
    endtask

    // monitor: every read-out must match the oldest outstanding hit of its channel
    always @(negedge array_clk) begin
        int k;
        if (reset && bus.rd_valid) begin
            k = -1;
            for (int j = 0; j < exp_q.size(); j++)
                if (exp_q[j].ch == int'(bus.rd_ch)) begin
                    k = j;
                    break;
                end
            total++;
            n_pop++;
            ch_log.push_back(int'(bus.rd_ch));
            if (k < 0) begin
                bad++;
                $display("FAIL record ch%0d: got q=%0d s=%0d len=%0d, none expected",
                         bus.rd_ch, bus.rd_q_addr, bus.rd_s_addr, bus.rd_len);
            end else begin
                if (int'(bus.rd_q_addr) != exp_q[k].q || int'(bus.rd_s_addr) != exp_q[k].s ||
                    int'(bus.rd_len) != exp_q[k].len) begin
                    bad++;
                    $display("FAIL record ch%0d: got q=%0d s=%0d len=%0d expected q=%0d s=%0d len=%0d",
                             bus.rd_ch, bus.rd_q_addr, bus.rd_s_addr, bus.rd_len,
                             exp_q[k].q, exp_q[k].s, exp_q[k].len);
                end
                exp_q.delete(k);
            end
        end
    end

    initial begin
        int p0;
        reset = 1'b0;
        bus.ch_valid = '0;
        bus.ch_q_addr = '0;
        bus.ch_s_addr = '0;
        bus.ch_len = '0;
        bus.min_len = '0;
        bus.rd_en = 1'b0;
        repeat (2) @(negedge array_clk);
        check("reset ch_ready", bus.ch_ready, 4'hF);
        check("reset rd_valid", bus.rd_valid, 0);
        check("reset rd_q_addr", bus.rd_q_addr, 0);
        check("reset rd_ch", bus.rd_ch, 0);
        check("reset empty", bus.empty, 1);
        check("reset full", bus.full, 0);
        check("reset count", bus.count, 0);
        check("reset filt_cnt", bus.filt_cnt, 0);
        reset = 1'b1;
        @(negedge array_clk);

        set_ch(0, 1'b1, 5, 9, 3);
        bus.rd_en = 1'b1;
        step();
        bus.ch_valid = '0;
        check("single empty after capture", bus.empty, 1);
        check("single rd_valid after capture", bus.rd_valid, 0);
        step();
        check("single empty after write", bus.empty, 0);
        check("single count after write", bus.count, 1);
        step();
        check("single rd_valid", bus.rd_valid, 1);
        check("single rd_q_addr", bus.rd_q_addr, 101);
        check("single rd_s_addr", bus.rd_s_addr, 9);
        check("single rd_len", bus.rd_len, 3);
        check("single rd_ch", bus.rd_ch, 0);
        check("single empty after pop", bus.empty, 1);
        drain();

        reset_pulse();
        ch_log.delete();
        bus.rd_en = 1'b1;
        for (int c = 0; c < 8; c++) begin
            for (int i = 0; i < NUM_CH; i++)
                rand_ch(i, 1'b1);
            step();
            check("fair count at most 1", bus.count <= 1, 1);
        end
        drain();
        check("fair record count", ch_log.size() >= 8, 1);
        for (int j = 0; j < 8 && j < ch_log.size(); j++)
            check($sformatf("fair grant %0d", j), ch_log[j], j % NUM_CH);

        reset_pulse();
        for (int c = 0; c < 20; c++) begin
            for (int i = 0; i < NUM_CH; i++)
                rand_ch(i, 1'b1);
            step();
        end
        check("full asserted", bus.full, 1);
        check("full count", bus.count, DEPTH);
        check("full ch_ready", bus.ch_ready, 0);
        bus.rd_en = 1'b1;
        step();
        check("full pop count", bus.count, DEPTH - 1);
        check("full pop full", bus.full, 0);
        bus.rd_en = 1'b0;
        step();
        check("full refill count", bus.count, DEPTH);
        check("full refill full", bus.full, 1);
        drain();

        p0 = n_pop;
        set_ch(0, 1'b1, 200, 1, 1);
        bus.rd_en = 1'b1;
        step();
        bus.ch_valid = '0;
        step();
        step();
        check("wrap rd_valid", bus.rd_valid, 1);
        check("wrap rd_q_addr", bus.rd_q_addr, 40);
        for (int c = 0; c < 40; c++) begin
            rand_ch(0, 1'b1);
            step();
        end
        drain();
        check("wrap pops", n_pop - p0, 41);

        bus.rd_en = 1'b0;
        for (int i = 0; i < 3; i++)
            rand_ch(i, 1'b1);
        step();
        bus.ch_valid = '0;
        step();
        step();
        rand_ch(0, 1'b1);
        rand_ch(3, 1'b1);
        step();
        bus.ch_valid = '0;
        check("pre-reset count", bus.count, 3);
        #1 reset = 1'b0;
        exp_q.delete();
        exp_filt = 0;
        #1;
        check("midreset empty", bus.empty, 1);
        check("midreset count", bus.count, 0);
        check("midreset rd_valid", bus.rd_valid, 0);
        check("midreset ch_ready", bus.ch_ready, 4'hF);
        @(negedge array_clk);
        reset = 1'b1;
        @(negedge array_clk);
        p0 = n_pop;
        rand_ch(2, 1'b1);
        step();
        drain();
        check("post-reset pops", n_pop - p0, 1);

        p0 = n_pop;
        bus.min_len = 8'd4;
        bus.rd_en = 1'b0;
        set_ch(1, 1'b1, 10, 20, 2);
        step();
        set_ch(1, 1'b1, 11, 21, 4);
        step();
        set_ch(1, 1'b1, 12, 22, 7);
        step();
        drain();
        check("filter pops", n_pop - p0, FILT_ON != 0 ? 2 : 3);
        check("filter filt_cnt", bus.filt_cnt, FILT_ON != 0 ? 1 : 0);

        for (int c = 0; c < 400; c++) begin
            bus.min_len = LEN_W'($urandom_range(0, 8));
            for (int i = 0; i < NUM_CH; i++)
                rand_ch(i, 1'($urandom_range(0, 1)));
            bus.rd_en = ($urandom_range(0, 3) != 0);
            step();
            if (bus.count > DEPTH) check("random count bound", bus.count, DEPTH);
        end
        drain();
        check("random filt_cnt", bus.filt_cnt, exp_filt);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
